// File: rtl/lpif_x4_asym2_pkg.sv
// lpif_x4_asym2_pkg: LPIF x4 asym2 logic-link word layout shared by master and slave mappings
package lpif_x4_asym2_pkg;
  localparam int LPIF_WORD_W   = 77;
  localparam int STATE_OFF     = 0;
  localparam int STATE_W       = 4;
  localparam int PROTID_OFF    = 4;
  localparam int PROTID_W      = 2;
  localparam int DATA_OFF      = 6;
  localparam int DATA_W        = 64;
  localparam int DVALID_OFF    = 70;
  localparam int CRC_OFF       = 71;
  localparam int CRC_W         = 4;
  localparam int CRC_VALID_OFF = 75;
  localparam int VALID_OFF     = 76;
  typedef struct packed {
    logic                valid;
    logic                crc_valid;
    logic [CRC_W-1:0]    crc;
    logic                dvalid;
    logic [DATA_W-1:0]   data;
    logic [PROTID_W-1:0] protid;
    logic [STATE_W-1:0]  state;
  } lpif_word_t;
  function automatic logic [DATA_W-1:0] gen2_mask(logic [DATA_W-1:0] d, logic gen2);
    return gen2 ? d : {{(DATA_W/2){1'b0}}, d[DATA_W/2-1:0]};
  endfunction
  function automatic logic [LPIF_WORD_W-1:0] pack_word(
    logic [STATE_W-1:0] st, logic [PROTID_W-1:0] pid, logic [DATA_W-1:0] d, logic dv,
    logic [CRC_W-1:0] c, logic cv, logic v, logic gen2);
    logic [LPIF_WORD_W-1:0] w;
    w[STATE_OFF +: STATE_W]   = st;
    w[PROTID_OFF +: PROTID_W] = pid;
    w[DATA_OFF +: DATA_W]     = gen2_mask(d, gen2);
    w[DVALID_OFF]             = dv;
    w[CRC_OFF +: CRC_W]       = c;
    w[CRC_VALID_OFF]          = cv;
    w[VALID_OFF]              = v;
    return w;
  endfunction
  function automatic lpif_word_t unpack_word(logic [LPIF_WORD_W-1:0] w, logic gen2);
    lpif_word_t u;
    u = lpif_word_t'(w);
    u.data = gen2_mask(u.data, gen2);
    return u;
  endfunction
endpackage

// File: rtl/lpif_sync_fifo.sv
// lpif_sync_fifo: single-clock FWFT FIFO; head output holds its last value while empty
module lpif_sync_fifo #(
  parameter int WIDTH = 77,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_vld,
  input  logic             i_rdy
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_last;
  logic             w_full;
  logic             w_empty;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_ready = !w_full;
  assign o_vld   = !w_empty;
  assign o_data  = w_empty ? r_last : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
    end else begin
      if (i_push && !w_full) r_wr <= r_wr + (AW+1)'(1);
      if (i_rdy && !w_empty) r_rd <= r_rd + (AW+1)'(1);
      r_last <= o_data;
    end
  end
  always_ff @(posedge i_clk)
    if (i_push && !w_full) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/lpif_txrx_x4_asym2_full_master_pipe.sv
// lpif_txrx_x4_asym2_full_master_pipe: master LPIF x4 asym2 adapter, TX pack via FWFT FIFO, RX registered unpack
module lpif_txrx_x4_asym2_full_master_pipe
  import lpif_x4_asym2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr_n,
  input  logic [3:0]             dstrm_state,
  input  logic [1:0]             dstrm_protid,
  input  logic [63:0]            dstrm_data,
  input  logic                   dstrm_dvalid,
  input  logic [3:0]             dstrm_crc,
  input  logic                   dstrm_crc_valid,
  input  logic                   dstrm_valid,
  input  logic                   dstrm_push,
  output logic                   dstrm_ready,
  output logic [LPIF_WORD_W-1:0] txfifo_downstream_data,
  output logic                   txfifo_downstream_vld,
  input  logic                   txfifo_downstream_rdy,
  input  logic [LPIF_WORD_W-1:0] rxfifo_upstream_data,
  input  logic                   rxfifo_upstream_vld,
  output logic [3:0]             ustrm_state,
  output logic [1:0]             ustrm_protid,
  output logic [63:0]            ustrm_data,
  output logic                   ustrm_dvalid,
  output logic [3:0]             ustrm_crc,
  output logic                   ustrm_crc_valid,
  output logic                   ustrm_valid,
  output logic                   ustrm_state_chg,
  output logic [CNT_W-1:0]       ovf_cnt,
  input  logic                   m_gen2_mode
);
  logic [LPIF_WORD_W-1:0] w_tx_word;
  lpif_word_t             r_rx;
  logic [3:0]             r_prev_state;
  logic                   r_chg;
  logic [CNT_W-1:0]       r_ovf;
  assign w_tx_word = pack_word(dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
                               dstrm_crc, dstrm_crc_valid, dstrm_valid, m_gen2_mode);
  lpif_sync_fifo #(.WIDTH(LPIF_WORD_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk_wr),
    .i_rst_n (rst_wr_n),
    .i_push  (dstrm_push),
    .i_data  (w_tx_word),
    .o_ready (dstrm_ready),
    .o_data  (txfifo_downstream_data),
    .o_vld   (txfifo_downstream_vld),
    .i_rdy   (txfifo_downstream_rdy)
  );
  assign ustrm_state     = r_rx.state;
  assign ustrm_protid    = r_rx.protid;
  assign ustrm_data      = r_rx.data;
  assign ustrm_dvalid    = r_rx.dvalid;
  assign ustrm_crc       = r_rx.crc;
  assign ustrm_crc_valid = r_rx.crc_valid;
  assign ustrm_valid     = r_rx.valid;
  assign ustrm_state_chg = r_chg;
  assign ovf_cnt         = r_ovf;
  // state_chg compares the registered state against its one-cycle-old copy, so it trails the change by a cycle
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      r_rx         <= '0;
      r_prev_state <= '0;
      r_chg        <= 1'b0;
      r_ovf        <= '0;
    end else begin
      if (rxfifo_upstream_vld) r_rx <= unpack_word(rxfifo_upstream_data, m_gen2_mode);
      else begin
        r_rx.valid     <= 1'b0;
        r_rx.dvalid    <= 1'b0;
        r_rx.crc_valid <= 1'b0;
      end
      r_prev_state <= r_rx.state;
      r_chg        <= r_rx.state != r_prev_state;
      if (dstrm_push && !dstrm_ready && !(&r_ovf)) r_ovf <= r_ovf + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_lpif_txrx_x4_asym2_full_master_pipe.sv
// tb_lpif_txrx_x4_asym2_full_master_pipe: directed + randomized bench against a queue-based reference model
module tb_lpif_txrx_x4_asym2_full_master_pipe;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  logic              clk_wr = 1'b0;
  logic              rst_wr_n;
  logic [3:0]        dstrm_state;
  logic [1:0]        dstrm_protid;
  logic [63:0]       dstrm_data;
  logic              dstrm_dvalid;
  logic [3:0]        dstrm_crc;
  logic              dstrm_crc_valid;
  logic              dstrm_valid;
  logic              dstrm_push;
  logic              dstrm_ready;
  logic [76:0]       txfifo_downstream_data;
  logic              txfifo_downstream_vld;
  logic              txfifo_downstream_rdy;
  logic [76:0]       rxfifo_upstream_data;
  logic              rxfifo_upstream_vld;
  logic [3:0]        ustrm_state;
  logic [1:0]        ustrm_protid;
  logic [63:0]       ustrm_data;
  logic              ustrm_dvalid;
  logic [3:0]        ustrm_crc;
  logic              ustrm_crc_valid;
  logic              ustrm_valid;
  logic              ustrm_state_chg;
  logic [CNT_W-1:0]  ovf_cnt;
  logic              m_gen2_mode;
  int                n_vec = 0;
  int                n_err = 0;
  logic [76:0]       q[$];
  logic [76:0]       last_head;
  bit                head_known;
  logic [CNT_W-1:0]  m_ovf;
  logic [3:0]        e_state, e_crc, s1, s2;
  logic [1:0]        e_pid;
  logic [63:0]       e_data;
  logic              e_dv, e_cv, e_v, e_chg;
  lpif_txrx_x4_asym2_full_master_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .dstrm_push(dstrm_push), .dstrm_ready(dstrm_ready),
    .txfifo_downstream_data(txfifo_downstream_data), .txfifo_downstream_vld(txfifo_downstream_vld),
    .txfifo_downstream_rdy(txfifo_downstream_rdy),
    .rxfifo_upstream_data(rxfifo_upstream_data), .rxfifo_upstream_vld(rxfifo_upstream_vld),
    .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
    .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
    .ustrm_valid(ustrm_valid), .ustrm_state_chg(ustrm_state_chg), .ovf_cnt(ovf_cnt),
    .m_gen2_mode(m_gen2_mode)
  );
  always #5 clk_wr = ~clk_wr;
  task automatic check(string tag, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] mask(logic [63:0] d, logic g2);
    return g2 ? d : (d & 64'h0000_0000_FFFF_FFFF);
  endfunction
  // one clock: advance the reference model from the current inputs, clock, then compare
  task automatic step();
    bit full, empty;
    logic [76:0] rw;
    if (!rst_wr_n) begin
      q.delete();
      m_ovf = '0;
      head_known = 0;
      {e_state, e_pid, e_data, e_dv, e_crc, e_cv, e_v, e_chg} = '0;
      s1 = '0;
      s2 = '0;
    end else begin
      full  = q.size() == DEPTH;
      empty = q.size() == 0;
      if (dstrm_push && full && m_ovf != {CNT_W{1'b1}}) m_ovf = m_ovf + 1'b1;
      if (txfifo_downstream_rdy && !empty) void'(q.pop_front());
      if (dstrm_push && !full)
        q.push_back({dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                     mask(dstrm_data, m_gen2_mode), dstrm_protid, dstrm_state});
      e_chg = s1 != s2;
      if (rxfifo_upstream_vld) begin
        rw      = rxfifo_upstream_data;
        e_state = rw[3:0];
        e_pid   = rw[5:4];
        e_data  = mask(rw[69:6], m_gen2_mode);
        e_dv    = rw[70];
        e_crc   = rw[74:71];
        e_cv    = rw[75];
        e_v     = rw[76];
      end else {e_dv, e_cv, e_v} = 3'b000;
      s2 = s1;
      s1 = e_state;
    end
    @(posedge clk_wr);
    #1;
    check("ready", 128'(dstrm_ready), 128'(q.size() < DEPTH));
    check("tx_vld", 128'(txfifo_downstream_vld), 128'(q.size() != 0));
    if (q.size() != 0) begin
      last_head  = q[0];
      head_known = 1;
    end
    if (head_known) check("tx_data", 128'(txfifo_downstream_data), 128'(last_head));
    check("ovf_cnt", 128'(ovf_cnt), 128'(m_ovf));
    check("u_state", 128'(ustrm_state), 128'(e_state));
    check("u_protid", 128'(ustrm_protid), 128'(e_pid));
    check("u_data", 128'(ustrm_data), 128'(e_data));
    check("u_crc", 128'(ustrm_crc), 128'(e_crc));
    check("u_flags", 128'({ustrm_valid, ustrm_crc_valid, ustrm_dvalid}), 128'({e_v, e_cv, e_dv}));
    check("u_chg", 128'(ustrm_state_chg), 128'(e_chg));
  endtask
  task automatic set_tx(logic [3:0] st, logic [1:0] pid, logic [63:0] d, logic dv,
                        logic [3:0] c, logic cv, logic v);
    dstrm_state = st; dstrm_protid = pid; dstrm_data = d;
    dstrm_dvalid = dv; dstrm_crc = c; dstrm_crc_valid = cv; dstrm_valid = v;
  endtask
  task automatic rand_tx();
    set_tx(4'($urandom), 2'($urandom), {$urandom, $urandom}, 1'($urandom),
           4'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic rand_rx();
    rxfifo_upstream_data = {1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                            $urandom, $urandom, 2'($urandom), 4'($urandom_range(0, 3))};
  endtask
  initial begin
    rst_wr_n = 1'b0;
    set_tx(4'h0, 2'h0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    dstrm_push = 1'b0;
    txfifo_downstream_rdy = 1'b0;
    rxfifo_upstream_data = '0;
    rxfifo_upstream_vld = 1'b0;
    m_gen2_mode = 1'b1;
    step();
    step();
    rst_wr_n = 1'b1;
    step();
    // single push appears on the next cycle
    set_tx(4'h3, 2'h1, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'h0, 1'b0, 1'b1);
    dstrm_push = 1'b1;
    txfifo_downstream_rdy = 1'b1;
    step();
    check("t1_bit76", 128'(txfifo_downstream_data[76]), 128'(1));
    check("t1_payload", 128'(txfifo_downstream_data[69:6]), 128'(64'hDEAD_BEEF_0123_4567));
    check("t1_state", 128'(txfifo_downstream_data[3:0]), 128'(4'h3));
    dstrm_push = 1'b0;
    step();
    // overflow: six pushes into a stalled four-entry FIFO
    txfifo_downstream_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_tx();
      dstrm_push = 1'b1;
      step();
    end
    dstrm_push = 1'b0;
    check("ovf_two", 128'(ovf_cnt), 128'(2));
    txfifo_downstream_rdy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    // full FIFO with simultaneous push and pop
    txfifo_downstream_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_tx();
      dstrm_push = 1'b1;
      step();
    end
    rand_tx();
    txfifo_downstream_rdy = 1'b1;
    step();
    check("ovf_three", 128'(ovf_cnt), 128'(3));
    dstrm_push = 1'b0;
    txfifo_downstream_rdy = 1'b0;
    step();
    check("occ3_ready", 128'(dstrm_ready), 128'(1));
    txfifo_downstream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("drained", 128'(txfifo_downstream_vld), 128'(0));
    // RX valid then a gap
    rxfifo_upstream_data = {1'b1, 1'b1, 4'hA, 1'b0, 64'h1234_5678_9ABC_DEF0, 2'h2, 4'h7};
    rxfifo_upstream_vld = 1'b1;
    step();
    check("rx_valid1", 128'(ustrm_valid), 128'(1));
    rxfifo_upstream_vld = 1'b0;
    step();
    check("rx_valid0", 128'(ustrm_valid), 128'(0));
    check("rx_crc_hold", 128'(ustrm_crc), 128'(4'hA));
    // state sequence 2,2,5
    rxfifo_upstream_vld = 1'b1;
    rxfifo_upstream_data = {1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 2'h0, 4'h2};
    step();
    step();
    rxfifo_upstream_data[3:0] = 4'h5;
    step();
    check("chg_at_5", 128'(ustrm_state_chg), 128'(0));
    rxfifo_upstream_vld = 1'b0;
    step();
    check("chg_pulse", 128'(ustrm_state_chg), 128'(1));
    step();
    check("chg_clear", 128'(ustrm_state_chg), 128'(0));
    // gen2 masking on both paths
    m_gen2_mode = 1'b0;
    txfifo_downstream_rdy = 1'b0;
    set_tx(4'h1, 2'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'h0, 1'b0, 1'b1);
    dstrm_push = 1'b1;
    rxfifo_upstream_data = {1'b1, 1'b0, 4'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'h0, 4'h5};
    rxfifo_upstream_vld = 1'b1;
    step();
    check("g2_tx", 128'(txfifo_downstream_data[69:6]), 128'(64'h0000_0000_FFFF_FFFF));
    check("g2_rx", 128'(ustrm_data), 128'(64'h0000_0000_FFFF_FFFF));
    m_gen2_mode = 1'b1;
    rxfifo_upstream_vld = 1'b0;
    rand_tx();
    step();
    rand_tx();
    step();
    dstrm_push = 1'b0;
    txfifo_downstream_rdy = 1'b1;
    step();
    // reset in the middle of a drain
    rst_wr_n = 1'b0;
    step();
    check("rst_vld", 128'(txfifo_downstream_vld), 128'(0));
    check("rst_ovf", 128'(ovf_cnt), 128'(0));
    rst_wr_n = 1'b1;
    step();
    check("rst_ready", 128'(dstrm_ready), 128'(1));
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_tx();
      rand_rx();
      dstrm_push = $urandom_range(0, 3) != 0;
      txfifo_downstream_rdy = $urandom_range(0, 2) != 0;
      rxfifo_upstream_vld = $urandom_range(0, 1) != 0;
      m_gen2_mode = $urandom_range(0, 7) != 0;
      rst_wr_n = $urandom_range(0, 99) != 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
